fp_add_sequencer: RTL and testbench

FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

---
 rtl/fp_seq_pkg.sv | 30 +++
 rtl/rise_detect.sv | 21 ++
 rtl/fp_add_sequencer.sv | 113 +++++++++++
 tb/tb_fp_add_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the floating-point add stage sequencer.
package fp_seq_pkg;

    localparam int unsigned NUM_STAGES = 4;
    localparam int unsigned DWELL_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_DONE = 3'd5
    } seq_state_t;

    function automatic logic is_stage(input seq_state_t s);
        return (s == ST_S1) || (s == ST_S2) || (s == ST_S3) || (s == ST_S4);
    endfunction

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input seq_state_t s);
        case (s)
            ST_S1:   return 4'b0001;
            ST_S2:   return 4'b0010;
            ST_S3:   return 4'b0100;
            ST_S4:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: pulse is high in the cycle where in=1 and the previous sample was 0.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/fp_add_sequencer.sv
// Four-stage FP adder sequencer with manual stepping and optional auto dwell stepping.
// Define FP_ADD_SEQ_AUTO_EN to build auto mode and the dwell counter.
module fp_add_sequencer
    import fp_seq_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  manual,
    input  logic                  step,
    input  logic                  ack,
    input  logic                  overflow_in,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_led,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic                  ovf_flag,
    output logic                  disp_exp
);

    seq_state_t state;
    seq_state_t state_nx;
    logic       step_pulse;
    logic       advance;
    logic       stage_entry;

    rise_detect u_step_edge (
        .clk   (clk),
        .reset (reset),
        .in    (step),
        .pulse (step_pulse)
    );

    assign stage_entry = is_stage(state_nx) && (state_nx != state);

`ifdef FP_ADD_SEQ_AUTO_EN
    logic [DWELL_W-1:0] dwell;

    // Held at zero in manual mode so a switch back to auto restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell <= '0;
        end else if (stage_entry || manual || !is_stage(state_nx)) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + DWELL_W'(1);
        end
    end

    assign advance = manual ? step_pulse : (dwell == DWELL_W'(STEP_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg = manual | (STEP_CYCLES == 0);
    assign advance    = step_pulse;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start)   state_nx = ST_S1;
            ST_S1:   if (advance) state_nx = ST_S2;
            ST_S2:   if (advance) state_nx = ST_S3;
            ST_S3:   if (advance) state_nx = ST_S4;
            ST_S4:   if (advance) state_nx = ST_DONE;
            ST_DONE: begin
                if (start) begin
                    state_nx = ST_S1;
                end else if (ack) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_en     <= '0;
            stage_led    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            ovf_flag     <= 1'b0;
            disp_exp     <= 1'b0;
        end else begin
            stage_en     <= stage_entry ? stage_onehot(state_nx) : '0;
            stage_led    <= stage_onehot(state_nx);
            busy         <= is_stage(state_nx);
            done         <= (state_nx == ST_DONE) && (state != ST_DONE);
            result_valid <= (state_nx == ST_DONE);
            disp_exp     <= (state_nx == ST_S3);
            if ((state == ST_S4) && (state_nx == ST_DONE)) begin
                ovf_flag <= overflow_in;
            end else if ((state_nx == ST_S1) && (state != ST_S1)) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer; auto-mode scenarios run when FP_ADD_SEQ_AUTO_EN is defined.
module tb_fp_add_sequencer;

    localparam int unsigned SC = 4;

    logic       clk = 1'b0;
    logic       reset, start, manual, step, ack, overflow_in;
    logic [3:0] stage_en, stage_led;
    logic       busy, done, result_valid, ovf_flag, disp_exp;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: stage number 0 = idle, 1..4 = stages, 5 = done
    int          m_stage;
    bit          m_prev;
    bit          m_ovf;
    int          m_dwell;
    logic [12:0] m_vec;

    always #5 clk = ~clk;

    fp_add_sequencer #(.STEP_CYCLES(SC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .manual       (manual),
        .step         (step),
        .ack          (ack),
        .overflow_in  (overflow_in),
        .stage_en     (stage_en),
        .stage_led    (stage_led),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .ovf_flag     (ovf_flag),
        .disp_exp     (disp_exp)
    );

    wire [12:0] dut_vec = {stage_en, stage_led, busy, done, result_valid, ovf_flag, disp_exp};

    function automatic logic [3:0] onehot(input int s);
        return (s >= 1 && s <= 4) ? 4'(1 << (s - 1)) : 4'b0000;
    endfunction

    task automatic model_reset();
        m_stage = 0;
        m_prev  = 1'b0;
        m_ovf   = 1'b0;
        m_dwell = 0;
        m_vec   = '0;
    endtask

    task automatic model_update();
        int old_s;
        bit pulse;
        bit man;
        bit adv;
        if (reset) begin
            model_reset();
            return;
        end
`ifdef FP_ADD_SEQ_AUTO_EN
        man = manual;
`else
        man = 1'b1;
`endif
        pulse  = step && !m_prev;
        m_prev = step;
        old_s  = m_stage;
        if (old_s == 0) begin
            if (start) m_stage = 1;
        end else if (old_s <= 4) begin
            adv = man ? pulse : (m_dwell == int'(SC) - 1);
            if (adv) m_stage = old_s + 1;
        end else begin
            if (start) m_stage = 1;
            else if (ack) m_stage = 0;
        end
        if (old_s == 4 && m_stage == 5) m_ovf = overflow_in;
        if (m_stage == 1 && old_s != 1) m_ovf = 1'b0;
        if (m_stage != old_s || man || m_stage == 0 || m_stage == 5) m_dwell = 0;
        else m_dwell++;
        m_vec = {(m_stage != old_s) ? onehot(m_stage) : 4'b0000, onehot(m_stage),
                 (m_stage >= 1 && m_stage <= 4), (m_stage == 5 && old_s != 5),
                 (m_stage == 5), m_ovf, (m_stage == 3)};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; manual = 1'b1; step = 1'b0; ack = 1'b0; overflow_in = 1'b0;
        model_reset();
        repeat (2) next_cycle();
        tests_run++;
        if (dut_vec !== 13'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want %b", dut_vec, 13'b0);
        end
        reset = 1'b0;
        next_cycle();
        tests_run++;
        if (dut_vec !== m_vec) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %b want %b", dut_vec, m_vec);
        end
    endtask

`ifdef FP_ADD_SEQ_AUTO_EN
    task automatic test_auto_latency();
        logic [3:0] exp_en;
        logic       exp_done;
        manual = 1'b0;
        start  = 1'b1;
        next_cycle();
        start  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            exp_en   = ((c - 1) % SC == 0 && c <= 1 + 3 * int'(SC)) ? 4'(1 << ((c - 1) / SC)) : 4'b0;
            exp_done = (c == 1 + 4 * int'(SC));
            tests_run++;
            if (stage_en !== exp_en || done !== exp_done) begin
                tests_failed++;
                $display("FAIL auto_timing cycle %0d: got en=%b done=%b want en=%b done=%b",
                         c, stage_en, done, exp_en, exp_done);
            end
            next_cycle();
        end
        ack = 1'b1;
        next_cycle();
        ack = 1'b0;
        tests_run++;
        if (dut_vec !== m_vec || m_stage != 0) begin
            tests_failed++;
            $display("FAIL auto_ack_idle: got %b want %b", dut_vec, m_vec);
        end
    endtask
`endif

    task automatic test_manual_step();
        manual = 1'b1;
        start  = 1'b1;
        next_cycle();
        start  = 1'b0;
        tests_run++;
        if (stage_led !== 4'b0001 || stage_en !== 4'b0001) begin
            tests_failed++;
            $display("FAIL manual_s1_entry: got led=%b en=%b want 0001/0001", stage_led, stage_en);
        end
        for (int p = 0; p < 4; p++) begin
            repeat (9) begin
                next_cycle();
                tests_run++;
                if (dut_vec !== m_vec) begin
                    tests_failed++;
                    $display("FAIL manual_dwell step %0d: got %b want %b", p, dut_vec, m_vec);
                end
            end
            step = 1'b1;
            next_cycle();
            step = 1'b0;
            tests_run++;
            if (stage_led !== onehot(p + 2) || stage_en !== onehot(p + 2) ||
                result_valid !== (p == 3) || done !== (p == 3)) begin
                tests_failed++;
                $display("FAIL manual_advance %0d: got led=%b en=%b rv=%b done=%b want led=%b",
                         p, stage_led, stage_en, result_valid, done, onehot(p + 2));
            end
        end
        ack = 1'b1;
        next_cycle();
        ack = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        step  = 1'b1;
        repeat (50) begin
            next_cycle();
            tests_run++;
            if (dut_vec !== m_vec) begin
                tests_failed++;
                $display("FAIL held_step_cycle: got %b want %b", dut_vec, m_vec);
            end
        end
        step = 1'b0;
        next_cycle();
        tests_run++;
        if (stage_led !== 4'b0010) begin
            tests_failed++;
            $display("FAIL held_step_single: got led=%b want 0010", stage_led);
        end
    endtask

    task automatic test_start_busy();
        start = 1'b1;
        repeat (3) begin
            next_cycle();
            tests_run++;
            if (stage_led !== 4'b0010 || stage_en !== 4'b0000 || ovf_flag !== m_ovf) begin
                tests_failed++;
                $display("FAIL start_while_busy: got led=%b en=%b want 0010/0000", stage_led, stage_en);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_overflow();
        pulse_step();
        pulse_step();
        overflow_in = 1'b1;
        step = 1'b1;
        next_cycle();
        step = 1'b0;
        overflow_in = 1'b0;
        next_cycle();
        tests_run++;
        if (ovf_flag !== 1'b1 || result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_capture: got ovf=%b rv=%b want 1/1", ovf_flag, result_valid);
        end
        start = 1'b1;
        ack   = 1'b1;
        next_cycle();
        start = 1'b0;
        ack   = 1'b0;
        tests_run++;
        if (stage_led !== 4'b0001 || stage_en !== 4'b0001 || ovf_flag !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_ack_done: got led=%b en=%b ovf=%b rv=%b want 0001/0001/0/0",
                     stage_led, stage_en, ovf_flag, result_valid);
        end
    endtask

    task automatic test_reset_mid();
        pulse_step();
        pulse_step();
        tests_run++;
        if (disp_exp !== 1'b1 || stage_led !== 4'b0100) begin
            tests_failed++;
            $display("FAIL reach_s3: got disp=%b led=%b want 1/0100", disp_exp, stage_led);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (dut_vec !== 13'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b want %b", dut_vec, 13'b0);
        end
        repeat (2) begin
            next_cycle();
            tests_run++;
            if (dut_vec !== m_vec || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold: got %b want %b", dut_vec, m_vec);
            end
        end
        reset = 1'b0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        tests_run++;
        if (stage_led !== 4'b0001 || stage_en !== 4'b0001) begin
            tests_failed++;
            $display("FAIL start_after_reset: got led=%b en=%b want 0001/0001", stage_led, stage_en);
        end
    endtask

    task automatic test_mode_switch();
        manual = 1'b0;
`ifdef FP_ADD_SEQ_AUTO_EN
        repeat (3 * SC) begin
            next_cycle();
            tests_run++;
            if (dut_vec !== m_vec) begin
                tests_failed++;
                $display("FAIL manual_to_auto: got %b want %b", dut_vec, m_vec);
            end
        end
`else
        repeat (100) begin
            next_cycle();
            tests_run++;
            if (stage_led !== 4'b0001 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL no_auto_stays_s1: got led=%b busy=%b want 0001/1", stage_led, busy);
            end
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom_range(7) == 0);
            ack         = ($urandom_range(3) == 0);
            overflow_in = $urandom_range(1);
            if ($urandom_range(2) == 0) step = ~step;
            if ($urandom_range(49) == 0) manual = ~manual;
            reset       = ($urandom_range(499) == 0);
            next_cycle();
            tests_run++;
            if (dut_vec !== m_vec) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got %b want %b", i, dut_vec, m_vec);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
`ifdef FP_ADD_SEQ_AUTO_EN
        test_auto_latency();
`endif
        test_manual_step();
        test_start_busy();
        test_overflow();
        test_reset_mid();
        test_mode_switch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
